// File: rtl/instruction_decode.sv
// Decode stage: splits the instruction word into register indices, immediate and
// control bundle, and holds the architectural register file written from writeback.
module instruction_decode #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [3:0]      funct,
  output logic [1:0]      alu_op,
  output logic            alu_src,
  output logic            branch,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            illegal
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  logic [XLEN-1:0]      regs_reg [NREGS];
  logic [6:0]           opcode;
  logic [1:0][4:0]      rd_idx;
  logic [1:0][XLEN-1:0] rd_val;

  assign opcode = inst[6:0];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];
  assign funct  = {inst[30], inst[14:12]};

  // Reset wins over a coincident writeback; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs_reg[wb_rd] <= wb_data;
    end
  end

  assign rd_idx = {rs2, rs1};

  // Combinational read ports with write-through bypass from writeback.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      assign rd_val[gi] = (rd_idx[gi] == 5'd0)                           ? '0 :
                          (!rst && wb_en && wb_rd == rd_idx[gi])         ? wb_data :
                                                                           regs_reg[rd_idx[gi]];
    end
  endgenerate

  assign rs1_data = rd_val[0];
  assign rs2_data = rd_val[1];

  always_comb begin
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OP_ADDI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b11;
      end
      OP_LD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
      end
      OP_SD: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        alu_op = 2'b01;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Branch offsets are byte offsets, so the B-format LSB is always zero.
  always_comb begin
    imm = '0;
    case (opcode)
      OP_ADDI, OP_LD: imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      OP_SD:          imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      OP_BEQ:         imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      default:        imm = '0;
    endcase
  end

endmodule
